trb_mem_ctrl: RTL and testbench

Capture-memory controller for the Streaming Trace Buffer. It sits between the Tracer's word interface (STORE/LOAD/DATA/TRG_EVENT) and an internal ring-buffer RAM. In trace mode it writes full trace words into the ring and applies the post-trigger delay. It returns the delayed trigger to the Tracer and freezes capture. In streaming mode it replays the captured words, oldest first, on the Tracer's load requests.

---
 rtl/dtb_pkg.sv | 27 ++
 rtl/trb_ram.sv | 42 ++++
 rtl/trb_mem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_trb_mem_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dtb_pkg.sv
// ---------------------------------------------------------------------------
// dtb_pkg
// Shared definitions for the Streaming Trace Buffer capture memory:
//   TRB_WIDTH / TRB_DEPTH  default trace word width and ring depth
//   trb_addr_t             ring address for the default depth
//   trb_fill_t             fill count for the default depth (0..TRB_DEPTH)
//   state_t                capture-memory controller states
// No ports.
// ---------------------------------------------------------------------------
package dtb_pkg;

  localparam int TRB_WIDTH = 32;
  localparam int TRB_DEPTH = 64;
  localparam int TRB_AW    = $clog2(TRB_DEPTH);

  typedef logic [TRB_AW-1:0] trb_addr_t;
  typedef logic [TRB_AW:0]   trb_fill_t;

  typedef enum logic [2:0] {
    st_idle,
    st_armed,
    st_delay,
    st_done,
    st_stream
  } state_t;

endpackage

// File: rtl/trb_ram.sv
// ---------------------------------------------------------------------------
// trb_ram
// Simple dual-port ring RAM: one write port and one read port. The read is
// registered, and a read and a write to the same address in the same cycle
// return the old word. rdata holds its value between reads. No reset.
// Ports:
//   FPGA_CLK_I  clock
//   we          write enable
//   waddr       write address
//   wdata       write data
//   re          read enable
//   raddr       read address
//   rdata       registered read data
// ---------------------------------------------------------------------------
module trb_ram #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             FPGA_CLK_I,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The read samples the array before the write updates it, which
  // gives read-first behaviour on an address collision.
  always_ff @(posedge FPGA_CLK_I) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/trb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// trb_mem_ctrl
// Capture-memory controller for the Streaming Trace Buffer. In trace mode it
// writes trace words into a ring and, after the trigger, accepts DELAY_I more
// stores before freezing capture. In stream mode it replays the ring oldest
// first on load requests.
// Ports:
//   FPGA_CLK_I   clock
//   RST_I        synchronous active-high reset
//   EN_I         run enable, low returns to idle
//   MODE_I       0 trace, 1 stream (sampled in idle)
//   DELAY_I      post-trigger store count (sampled on trigger)
//   TRG_EVENT_I  sticky trigger from the Tracer
//   STORE_I      store pulse, DATA_I is a complete word
//   DATA_I       word to store
//   LOAD_I       read request pulse
//   DATA_O       read word, held between reads
//   LOAD_O       one-cycle pulse, DATA_O is new
//   TRG_EVENT_O  delayed trigger (capture frozen)
//   DONE_O       capture frozen, same as TRG_EVENT_O
//   TRG_ADDR_O   ring address of the word stored in the trigger cycle
//   FILL_O       number of valid words in the ring
// ---------------------------------------------------------------------------
module trb_mem_ctrl #(
  parameter  int TRB_WIDTH = dtb_pkg::TRB_WIDTH,
  parameter  int TRB_DEPTH = dtb_pkg::TRB_DEPTH,
  parameter  int DELAY_W   = 16,
  localparam int AW        = $clog2(TRB_DEPTH)
) (
  input  logic                 FPGA_CLK_I,
  input  logic                 RST_I,
  input  logic                 EN_I,
  input  logic                 MODE_I,
  input  logic [DELAY_W-1:0]   DELAY_I,
  input  logic                 TRG_EVENT_I,
  input  logic                 STORE_I,
  input  logic [TRB_WIDTH-1:0] DATA_I,
  input  logic                 LOAD_I,
  output logic [TRB_WIDTH-1:0] DATA_O,
  output logic                 LOAD_O,
  output logic                 TRG_EVENT_O,
  output logic                 DONE_O,
  output logic [AW-1:0]        TRG_ADDR_O,
  output logic [AW:0]          FILL_O
);

  import dtb_pkg::*;

  localparam logic [AW:0] FILL_MAX = (AW+1)'(TRB_DEPTH);

  state_t               state;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        trg_addr;
  logic [AW:0]          fill;
  logic                 wrapped;
  logic [DELAY_W-1:0]   dly_cnt;
  logic [DELAY_W-1:0]   dly_lat;
  logic                 load_q;
  logic                 done_q;
  logic                 have_data;

  logic                 delay_open;
  logic                 ram_we;
  logic                 ram_re;
  logic [AW-1:0]        ram_raddr;
  logic [TRB_WIDTH-1:0] ram_rdata;

  // Write/read strobes to the ring. A disabled or resetting block never
  // touches the RAM. In st_delay the store that would exceed the latched
  // delay is refused. Trace-mode loads peek at the write pointer (oldest
  // word once wrapped); stream loads walk rd_ptr while words remain.
  always_comb begin
    delay_open = (dly_cnt != dly_lat);
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = wr_ptr;
    if (EN_I && !RST_I) begin
      ram_we = STORE_I &&
               ((state == st_armed) || ((state == st_delay) && delay_open));
      ram_re = LOAD_I &&
               ((state == st_armed) || (state == st_delay) ||
                (state == st_done)  || ((state == st_stream) && (fill != '0)));
    end
    if (state == st_stream) begin
      ram_raddr = rd_ptr;
    end
  end

  trb_ram #(
    .WIDTH (TRB_WIDTH),
    .DEPTH (TRB_DEPTH)
  ) u_ram (
    .FPGA_CLK_I (FPGA_CLK_I),
    .we         (ram_we),
    .waddr      (wr_ptr),
    .wdata      (DATA_I),
    .re         (ram_re),
    .raddr      (ram_raddr),
    .rdata      (ram_rdata)
  );

  // Controller FSM with pointers, fill accounting, post-trigger counter and
  // registered outputs. A dropped enable wins over everything else.
  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      state     <= st_idle;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      trg_addr  <= '0;
      fill      <= '0;
      wrapped   <= 1'b0;
      dly_cnt   <= '0;
      dly_lat   <= '0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      have_data <= 1'b0;
    end else begin
      load_q <= ram_re;
      if (ram_re) begin
        have_data <= 1'b1;
      end

      if (ram_we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (&wr_ptr) begin
          wrapped <= 1'b1;
        end
        if (fill != FILL_MAX) begin
          fill <= fill + 1'b1;
        end
      end

      if (!EN_I) begin
        state  <= st_idle;
        done_q <= 1'b0;
      end else begin
        case (state)
          st_idle: begin
            if (MODE_I) begin
              state  <= st_stream;
              rd_ptr <= wrapped ? wr_ptr : '0;
            end else begin
              state   <= st_armed;
              wr_ptr  <= '0;
              fill    <= '0;
              wrapped <= 1'b0;
            end
          end
          st_armed: begin
            if (TRG_EVENT_I) begin
              trg_addr <= wr_ptr;
              dly_lat  <= DELAY_I;
              dly_cnt  <= '0;
              state    <= st_delay;
            end
          end
          st_delay: begin
            // Freeze either when the count is already met (delay 0) or
            // when this store is the last one counted.
            if (!delay_open) begin
              state  <= st_done;
              done_q <= 1'b1;
            end else if (STORE_I) begin
              dly_cnt <= dly_cnt + 1'b1;
              if ((dly_cnt + 1'b1) == dly_lat) begin
                state  <= st_done;
                done_q <= 1'b1;
              end
            end
          end
          st_done: begin
            done_q <= 1'b1;
          end
          st_stream: begin
            if (ram_re) begin
              rd_ptr <= rd_ptr + 1'b1;
              fill   <= fill - 1'b1;
            end
          end
          default: begin
            state <= st_idle;
          end
        endcase
      end
    end
  end

  // The RAM has no reset, so DATA_O reads as zero until the first read
  // after reset completes.
  assign DATA_O      = have_data ? ram_rdata : '0;
  assign LOAD_O      = load_q;
  assign TRG_EVENT_O = done_q;
  assign DONE_O      = done_q;
  assign TRG_ADDR_O  = trg_addr;
  assign FILL_O      = fill;

endmodule

// File: tb/tb_trb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trb_mem_ctrl
// Self-checking bench for trb_mem_ctrl at TRB_DEPTH=8, TRB_WIDTH=32.
// ---------------------------------------------------------------------------
module tb_trb_mem_ctrl;

  typedef struct {
    bit          rst;
    bit          en;
    bit          mode;
    bit          trg;
    bit          st;
    bit          ld;
    logic [15:0] dly;
    logic [31:0] data;
    int          fill;
    int          trgo;
    int          addr;
    bit          rd;
    logic [31:0] rdat;
  } vec_t;

  logic        clk;
  logic        RST_I;
  logic        EN_I;
  logic        MODE_I;
  logic [15:0] DELAY_I;
  logic        TRG_EVENT_I;
  logic        STORE_I;
  logic [31:0] DATA_I;
  logic        LOAD_I;
  logic [31:0] DATA_O;
  logic        LOAD_O;
  logic        TRG_EVENT_O;
  logic        DONE_O;
  logic [2:0]  TRG_ADDR_O;
  logic [3:0]  FILL_O;

  int          n_vec;
  int          n_fail;
  int          cyc_no;
  bit          seen;
  logic [31:0] exp_q[$];
  vec_t        tbl[$];

  trb_mem_ctrl #(
    .TRB_WIDTH (32),
    .TRB_DEPTH (8),
    .DELAY_W   (16)
  ) dut (
    .FPGA_CLK_I  (clk),
    .RST_I       (RST_I),
    .EN_I        (EN_I),
    .MODE_I      (MODE_I),
    .DELAY_I     (DELAY_I),
    .TRG_EVENT_I (TRG_EVENT_I),
    .STORE_I     (STORE_I),
    .DATA_I      (DATA_I),
    .LOAD_I      (LOAD_I),
    .DATA_O      (DATA_O),
    .LOAD_O      (LOAD_O),
    .TRG_EVENT_O (TRG_EVENT_O),
    .DONE_O      (DONE_O),
    .TRG_ADDR_O  (TRG_ADDR_O),
    .FILL_O      (FILL_O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, want $finish");
    $fatal(1, "[TB] watchdog");
  end

  // fill/trgo/addr of -1 mean "do not check"; rd pushes rdat as the word
  // expected on LOAD_O one cycle later.
  function automatic vec_t cyc(bit rst, bit en, bit mode, bit trg, bit st,
                               bit ld, logic [15:0] dly, logic [31:0] data,
                               int fill, int trgo, int addr, bit rd,
                               logic [31:0] rdat);
    vec_t v;
    v.rst  = rst;  v.en   = en;   v.mode = mode; v.trg = trg;
    v.st   = st;   v.ld   = ld;   v.dly  = dly;  v.data = data;
    v.fill = fill; v.trgo = trgo; v.addr = addr; v.rd  = rd;
    v.rdat = rdat;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s @cycle %0d: got %0h, want %0h",
               name, cyc_no, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    RST_I       = v.rst;
    EN_I        = v.en;
    MODE_I      = v.mode;
    DELAY_I     = v.dly;
    TRG_EVENT_I = v.trg;
    STORE_I     = v.st;
    DATA_I      = v.data;
    LOAD_I      = v.ld;
    if (v.rd) exp_q.push_back(v.rdat);
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [31:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp("load_o", 32'(LOAD_O), 32'd1);
      if (LOAD_O) cmp("data_o", DATA_O, e);
    end else if (v.ld || LOAD_O) begin
      cmp("load_o_quiet", 32'(LOAD_O), 32'd0);
    end
    if (v.fill >= 0) cmp("fill_o", 32'(FILL_O), 32'(v.fill));
    if (v.trgo >= 0) begin
      cmp("trg_event_o", 32'(TRG_EVENT_O), 32'(v.trgo));
      cmp("done_o", 32'(DONE_O), 32'(v.trgo));
    end
    if (v.addr >= 0) cmp("trg_addr_o", 32'(TRG_ADDR_O), 32'(v.addr));
    if (v.rst) begin
      cmp("rst_data_o", DATA_O, 32'd0);
      cmp("rst_load_o", 32'(LOAD_O), 32'd0);
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    checkOutput(v);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    cyc_no = 0;
    RST_I = 1'b1; EN_I = 1'b0; MODE_I = 1'b0; DELAY_I = '0;
    TRG_EVENT_I = 1'b0; STORE_I = 1'b0; DATA_I = '0; LOAD_I = 1'b0;

    // Reset, arm, reset held two cycles during activity, re-arm.
    tbl.push_back(cyc(1,0,0,0,0,0,0,0,        0, 0, 0,0,0));
    tbl.push_back(cyc(0,1,0,0,0,0,0,0,        0,-1,-1,0,0));
    tbl.push_back(cyc(0,1,0,0,1,0,0,32'h11,   1,-1,-1,0,0));
    tbl.push_back(cyc(0,1,0,0,1,0,0,32'h12,   2,-1,-1,0,0));
    tbl.push_back(cyc(1,1,0,0,1,1,0,32'h13,   0, 0, 0,0,0));
    tbl.push_back(cyc(1,1,0,0,1,1,0,32'h14,   0, 0, 0,0,0));
    tbl.push_back(cyc(0,1,0,0,0,0,0,0,        0, 0,-1,0,0));
    tbl.push_back(cyc(0,1,0,0,1,0,0,32'h21,   1,-1,-1,0,0));
    tbl.push_back(cyc(0,0,0,0,0,0,0,0,        1, 0,-1,0,0));
    // Delay 3, trigger with store 2.
    tbl.push_back(cyc(0,1,0,0,0,0,3,0,        0, 0,-1,0,0));
    tbl.push_back(cyc(0,1,0,0,1,0,3,1,        1, 0,-1,0,0));
    tbl.push_back(cyc(0,1,0,1,1,0,3,2,        2, 0, 1,0,0));
    tbl.push_back(cyc(0,1,0,1,1,0,3,3,        3, 0, 1,0,0));
    tbl.push_back(cyc(0,1,0,1,1,0,3,4,        4, 0, 1,0,0));
    tbl.push_back(cyc(0,1,0,1,1,0,3,5,        5, 1, 1,0,0));
    tbl.push_back(cyc(0,1,0,1,1,0,3,6,        5, 1, 1,0,0));
    tbl.push_back(cyc(0,1,0,1,1,0,3,7,        5, 1, 1,0,0));
    tbl.push_back(cyc(0,0,0,1,0,0,3,0,        5, 0, 1,0,0));
    // Wrap with delay 0, then playback oldest first.
    tbl.push_back(cyc(0,1,0,0,0,0,0,0,        0, 0, 1,0,0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(cyc(0,1,0,0,1,0,0,32'hA0 + 32'(i),
                        (i < 8) ? i + 1 : 8, 0,-1,0,0));
    tbl.push_back(cyc(0,1,0,1,0,0,0,0,        8, 0, 2,0,0));
    tbl.push_back(cyc(0,1,0,1,0,0,0,0,        8, 1, 2,0,0));
    tbl.push_back(cyc(0,0,0,0,0,0,0,0,        8, 0, 2,0,0));
    tbl.push_back(cyc(0,1,1,0,0,0,0,0,        8, 0,-1,0,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(cyc(0,1,1,0,0,1,0,0, 7 - i, 0,-1,1,32'hA2 + 32'(i)));
    tbl.push_back(cyc(0,1,1,0,0,1,0,0,        0, 0,-1,0,0));
    tbl.push_back(cyc(0,0,0,0,0,0,0,0,        0, 0,-1,0,0));

    for (int k = 0; k < tbl.size(); k++) step(tbl[k]);

    // Collision: load and store to wr_ptr=2 in the same cycle reads old data.
    step(cyc(0,1,0,0,0,0,0,0, 0, 0,-1,0,0));
    for (int i = 0; i < 10; i++)
      step(cyc(0,1,0,0,1,0,0,32'hA0 + 32'(i), (i < 8) ? i + 1 : 8, 0,-1,0,0));
    step(cyc(0,1,0,0,1,1,0,32'hB0, 8, 0,-1,1,32'hA2));
    step(cyc(0,1,0,1,0,0,0,0,      8, 0, 3,0,0));
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(cyc(0,1,0,1,0,0,0,0, -1,-1,-1,0,0));
      if (TRG_EVENT_O) seen = 1'b1;
    end
    cmp("trg_wait", 32'(seen), 32'd1);
    step(cyc(0,0,0,0,0,0,0,0, 8, 0, 3,0,0));
    step(cyc(0,1,1,0,0,0,0,0, 8, 0,-1,0,0));
    for (int i = 0; i < 7; i++)
      step(cyc(0,1,1,0,0,1,0,0, 7 - i, 0,-1,1,32'hA3 + 32'(i)));
    step(cyc(0,1,1,0,0,1,0,0, 0, 0,-1,1,32'hB0));

    // Reset in the middle of a long post-trigger delay.
    step(cyc(0,0,0,0,0,0,0,0, 0, 0,-1,0,0));
    step(cyc(0,1,0,0,0,0,100,0, 0, 0,-1,0,0));
    step(cyc(0,1,0,1,0,0,100,0, 0, 0, 0,0,0));
    for (int i = 0; i < 10; i++)
      step(cyc(0,1,0,1,1,0,100,32'hD0 + 32'(i), (i < 8) ? i + 1 : 8, 0,-1,0,0));
    step(cyc(1,1,0,1,1,0,100,32'hDF, 0, 0, 0,0,0));
    step(cyc(0,0,0,0,0,0,0,0,        0, 0, 0,0,0));

    // Mode toggles while armed; enable dropped in the trigger cycle.
    step(cyc(0,1,0,0,0,0,0,0,       0, 0,-1,0,0));
    step(cyc(0,1,0,0,1,0,0,32'hC0,  1, 0,-1,0,0));
    step(cyc(0,1,1,0,1,0,0,32'hC1,  2, 0,-1,0,0));
    step(cyc(0,1,1,0,0,0,0,0,       2, 0,-1,0,0));
    step(cyc(0,1,0,0,1,0,0,32'hC2,  3, 0,-1,0,0));
    step(cyc(0,0,0,1,1,0,0,32'hC3,  3, 0, 0,0,0));
    step(cyc(0,1,0,0,0,0,0,0,       0, 0, 0,0,0));
    step(cyc(0,1,0,0,1,0,0,32'hC4,  1, 0, 0,0,0));
    step(cyc(0,1,0,1,0,0,0,0,       1, 0, 1,0,0));
    step(cyc(0,1,0,1,0,0,0,0,       1, 1, 1,0,0));

    cmp("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
